// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared types and constants for the FIFO stream reader.
package fifo_stream_pkg;

    // Burst sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Output buffer geometry: occupancy counts 0..BUF_DEPTH
    localparam int unsigned OCC_W = 2;
    localparam logic [OCC_W-1:0] BUF_DEPTH = OCC_W'(2);

    // A new pop may issue if buffered plus in-flight words leave a free slot,
    // or if the buffer is exactly full but the head is leaving this cycle.
    function automatic logic has_credit(input logic [OCC_W-1:0] occ,
                                        input logic             inflight,
                                        input logic             hs);
        logic [OCC_W:0] pending;
        pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
        return (pending < {1'b0, BUF_DEPTH}) ||
               ((pending == {1'b0, BUF_DEPTH}) && hs);
    endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// fifo_stream_skid: 2-entry registered buffer between the FIFO read port and
// the output stream. Head is the presented word; tail holds the second entry.
module fifo_stream_skid
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_LEN = 8
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic                wr,
    input  logic [DATA_LEN-1:0] wdata,
    input  logic                rd,
    output logic [OCC_W-1:0]    occ,
    output logic [DATA_LEN-1:0] head
);

    logic [DATA_LEN-1:0] tail;

    // Push/pop bookkeeping; head only changes when it is empty or being popped
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({wr, rd})
                2'b10: begin
                    if (occ == '0) head <= wdata;
                    else           tail <= wdata;
                    occ <= occ + OCC_W'(1);
                end
                2'b01: begin
                    if (occ == BUF_DEPTH) head <= tail;
                    occ <= occ - OCC_W'(1);
                end
                2'b11: begin
                    if (occ == BUF_DEPTH) begin
                        head <= tail;
                        tail <= wdata;
                    end else begin
                        head <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_rd.sv
// fifo_stream_rd: pops a burst of len words from a synchronous FIFO and
// presents them on a valid/ready stream with last, then pulses done.
// Optional macro FIFO_STREAM_BEAT_CNT_EN adds a saturating beat_total port.
module fifo_stream_rd
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_LEN  = 8,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DATA_LEN-1:0]  fifo_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_LEN-1:0]  m_data,
    output logic                 m_last
`ifdef FIFO_STREAM_BEAT_CNT_EN
    ,
    output logic [31:0]          beat_total
`endif
);

    state_t               state;
    logic [LEN_WIDTH-1:0] issue_cnt;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic                 inflight;
    logic [OCC_W-1:0]     occ;
    logic                 hs;
    logic                 credit;

    assign m_valid    = (occ != '0);
    assign hs         = m_valid && m_ready;
    assign m_last     = m_valid && (beat_cnt == LEN_WIDTH'(1));
    assign busy       = (state != IDLE);
    assign credit     = has_credit(occ, inflight, hs);
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (issue_cnt != '0) && credit;

    fifo_stream_skid #(
        .DATA_LEN (DATA_LEN)
    ) u_skid (
        .clk     (clk),
        .sys_rst (sys_rst),
        .wr      (inflight),
        .wdata   (fifo_data),
        .rd      (hs),
        .occ     (occ),
        .head    (m_data)
    );

    // FIFO data arrives one cycle after an accepted pop
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) inflight <= 1'b0;
        else         inflight <= fifo_rd_en;
    end

    // Burst sequencer: issue/beat counters and registered done pulse
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (hs) beat_cnt <= beat_cnt - LEN_WIDTH'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            issue_cnt <= len;
                            beat_cnt  <= len;
                            state     <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fifo_rd_en) begin
                        issue_cnt <= issue_cnt - LEN_WIDTH'(1);
                        if (issue_cnt == LEN_WIDTH'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Final beat leaving with nothing else buffered or in flight
                    if (hs && (beat_cnt == LEN_WIDTH'(1)) && !inflight &&
                        (occ == OCC_W'(1))) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_STREAM_BEAT_CNT_EN
    // Lifetime handshake count, saturating, cleared only by reset
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst)                    beat_total <= '0;
        else if (hs && beat_total != '1) beat_total <= beat_total + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_stream_rd.sv
// tb_fifo_stream_rd: bench for fifo_stream_rd with a behavioural FIFO and a
// scoreboard of expected stream beats.
module tb_fifo_stream_rd;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef FIFO_STREAM_BEAT_CNT_EN
    logic [31:0]   beat_total;
`endif

    fifo_stream_rd #(
        .DATA_LEN  (DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef FIFO_STREAM_BEAT_CNT_EN
        ,
        .beat_total (beat_total)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] fifo_q[$];
    bit            pend = 1'b0;

    task automatic push_word(input logic [DW-1:0] w, input logic last);
        fifo_q.push_back(w);
        sb.push_back(exp_t'{data: w, last: last});
    endtask

    // Behavioural FIFO: a pop requested before a rising edge shows its word
    // on fifo_data during the following cycle, zero otherwise.
    always begin
        @(negedge clk);
        if (sys_rst) begin
            pend      = 1'b0;
            fifo_data = '0;
        end else if (pend) begin
            checks++;
            if (fifo_q.size() == 0) begin
                failures++;
                $display("FAIL fifo_underflow: pop with empty fifo at %0t", $time);
                fifo_data = '0;
            end else begin
                fifo_data = fifo_q.pop_front();
            end
        end else begin
            fifo_data = '0;
        end
        fifo_empty = (fifo_q.size() == 0);
        #1;
        pend = fifo_rd_en && !sys_rst;
    end

    // Monitor: samples mid-cycle once all inputs for the cycle are settled
    int            cyc = 0;
    int            rd_cnt, hs_cnt, done_cnt;
    int            first_rd, last_rd, first_hs, last_hs, done_cyc, start_cyc;
    bit            busy_seen;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        cyc++;
        if (sys_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (start) start_cyc = cyc;
            if (busy) busy_seen = 1'b1;
            if (fifo_rd_en) begin
                if (rd_cnt == 0) first_rd = cyc;
                last_rd = cyc;
                rd_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_with_done", busy, 0);
            end
            check("last_without_valid", m_last & ~m_valid, 0);
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: unexpected beat %0h", m_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", m_data, e.data);
                    check("beat_last", m_last, e.last);
                end
                if (hs_cnt == 0) first_hs = cyc;
                last_hs = cyc;
                hs_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic clear_counters();
        rd_cnt = 0; hs_cnt = 0; done_cnt = 0; busy_seen = 1'b0;
        first_rd = 0; last_rd = 0; first_hs = 0; last_hs = 0;
        done_cyc = 0; start_cyc = 0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        check(name, done_cnt >= target, 1);
    endtask

    task automatic feed(input int n, input logic [DW-1:0] base, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #3;
            push_word(base + DW'(i), i == n - 1);
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    typedef struct {
        int            n;          // burst length
        logic [DW-1:0] base;       // first word, incrementing
        int            gap;        // 0: preloaded, else one word per gap cycles
        int            stall;      // cycles of m_ready=0 after start
        int            stall_pops; // pops expected during the stall
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int exp_total;

        vecs[0] = '{5, 8'h11, 0, 0,  0};
        vecs[1] = '{4, 8'h21, 0, 10, 2};
        vecs[2] = '{3, 8'h31, 3, 0,  0};
        vecs[3] = '{0, 8'h00, 0, 0,  0};
        vecs[4] = '{1, 8'h41, 0, 4,  1};
        vecs[5] = '{7, 8'h61, 0, 3,  2};

        sys_rst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b1;
        clear_counters();
        repeat (3) @(negedge clk);
        #3;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        @(negedge clk);
        sys_rst = 1'b0;

        // Reset in RUN with a full buffer abandons the burst
        @(negedge clk);
        #3;
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'hA0 + i));
        @(negedge clk);
        m_ready = 1'b0; start = 1'b1; len = LW'(4);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        check("prerst_valid", m_valid, 1);
        check("prerst_busy", busy, 1);
        sys_rst = 1'b1;
        @(negedge clk);
        #3;
        check("midrst_valid", m_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd_en", fifo_rd_en, 0);
        fifo_q.delete();
        sb.delete();
        clear_counters();
        @(negedge clk);
        sys_rst = 1'b0; m_ready = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_rd", rd_cnt, 0);

        exp_total = 3;
        for (int v = 0; v < NV; v++) begin
            exp_total += vecs[v].n;
            @(negedge clk);
            clear_counters();
            m_ready = (vecs[v].stall == 0);
            #3;
            if (vecs[v].gap == 0)
                for (int i = 0; i < vecs[v].n; i++)
                    push_word(vecs[v].base + DW'(i), i == vecs[v].n - 1);
            @(negedge clk);
            start = 1'b1; len = LW'(vecs[v].n);
            @(negedge clk);
            start = 1'b0;
            if (vecs[v].gap > 0)
                fork
                    feed(vecs[v].n, vecs[v].base, vecs[v].gap);
                join_none
            if (vecs[v].stall > 0) begin
                repeat (vecs[v].stall) @(negedge clk);
                check("stall_pops", rd_cnt, vecs[v].stall_pops);
                m_ready = 1'b1;
            end
            wait_done(1, 400, "done_timeout");
            repeat (3) @(negedge clk);
            #3;
            check("done_once", done_cnt, 1);
            check("beats", hs_cnt, vecs[v].n);
            check("pops", rd_cnt, vecs[v].n);
            check("sb_empty", sb.size(), 0);
            check("idle_busy", busy, 0);
            if (vecs[v].n == 0) begin
                check("len0_done_cyc", done_cyc, start_cyc + 1);
                check("len0_busy", busy_seen, 0);
            end else begin
                check("done_after_last", done_cyc, last_hs + 1);
            end
            if (vecs[v].n > 0 && vecs[v].gap == 0 && vecs[v].stall == 0) begin
                check("rd_consecutive", last_rd - first_rd, vecs[v].n - 1);
                check("hs_consecutive", last_hs - first_hs, vecs[v].n - 1);
                check("first_latency", first_hs - first_rd, 2);
            end
        end

        // start held across completion: second burst only after IDLE
        @(negedge clk);
        clear_counters();
        m_ready = 1'b1;
        #3;
        push_word(8'h71, 1'b0);
        push_word(8'h72, 1'b1);
        push_word(8'h73, 1'b1);
        @(negedge clk);
        start = 1'b1; len = LW'(2);
        repeat (2) @(negedge clk);
        len = LW'(1);
        wait_done(1, 100, "held_done1_timeout");
        check("held_no_early_pop", rd_cnt, 2);
        @(negedge clk);
        start = 1'b0;
        wait_done(2, 100, "held_done2_timeout");
        repeat (4) @(negedge clk);
        #3;
        check("held_done_cnt", done_cnt, 2);
        check("held_beats", hs_cnt, 3);
        check("held_pops", rd_cnt, 3);
        check("held_sb_empty", sb.size(), 0);

`ifdef FIFO_STREAM_BEAT_CNT_EN
        check("beat_total", beat_total, exp_total);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_stream_rd.md
Name: fifo_stream_rd

Overview:
Downstream consumer stage for the synchronous FIFO. On a start command it pops exactly `len` words from the FIFO via its rd_en/empty/data_out interface and presents them on a valid/ready stream with a last flag. Internally it absorbs the FIFO's one-cycle read latency and its "data_out = 0 when not reading" behaviour with a 2-entry output buffer. It then pulses done when the burst is complete.

Parameters:
DATA_LEN, 8, width of FIFO and stream data
LEN_WIDTH, 8, width of burst length; max burst 2^LEN_WIDTH-1 words

Ports:
clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  asynchronous, active-high reset
start  in  1  burst request; sampled only in IDLE
len  in  LEN_WIDTH  word count, sampled with start
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at burst completion
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO pop request
fifo_data  in  DATA_LEN  FIFO data_out, valid the cycle after an accepted pop
m_valid  out  1  stream data valid
m_ready  in  1  downstream accept
m_data  out  DATA_LEN  stream data
m_last  out  1  marks final beat of burst

Behaviour:
- Reset is asynchronous, active-high. It forces:
  - state = IDLE; buffer empty; all counters 0.
  - Outputs: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
- Reset mid-burst abandons the burst; no done pulse. The FIFO contents are not this block's responsibility.
- State IDLE:
  - start=1, len!=0: capture len into issue_cnt and beat_cnt, go to RUN.
  - start=1, len==0: done=1 next cycle, stay IDLE.
- State RUN:
  - fifo_rd_en is combinational: (state==RUN) & !fifo_empty & (issue_cnt!=0) & credit.
  - credit = (occ + inflight < 2) | (occ + inflight == 2 & m_valid & m_ready).
    - occ = buffer entries (0..2).
    - inflight = registered copy of previous fifo_rd_en.
  - Each asserted fifo_rd_en decrements issue_cnt. When issue_cnt reaches 0, go to DRAIN.
- State DRAIN: when occ==0, inflight==0 and the final handshake has occurred, pulse done=1 for one cycle and return to IDLE.
- Capture: if inflight=1, fifo_data is written into the buffer tail on that edge. fifo_data is never sampled otherwise.
- Latency: rd_en at edge T → data in buffer at T+1 → m_valid high after T+1.
- Sustained throughput is 1 beat/cycle when m_ready=1 and the FIFO is non-empty.
- Stream:
  - m_valid = occ!=0; m_data = buffer head, registered, no combinational path from fifo_data.
  - Once m_valid is high, m_data and m_last hold until handshake.
- Handshake = m_valid & m_ready. It pops the head and decrements beat_cnt.
- m_last = m_valid & (beat_cnt==1).
- Simultaneous capture and pop in one cycle: occ unchanged, order preserved.
- done is registered; it asserts the cycle after the last handshake.
- start while busy is ignored.
- busy falls in the same cycle done rises.
- m_ready=0 indefinitely: at most 2 words are popped ahead; rd_en stalls. No overflow.
- fifo_empty high mid-burst: rd_en stays low; the burst resumes when data arrives. There is no timeout.

Optional Feature:
Macro FIFO_STREAM_BEAT_CNT_EN.
- Defined: adds output port beat_total [31:0].
  - Increments on every handshake and saturates at 0xFFFFFFFF.
  - Reset to 0 only by sys_rst; it is not cleared by start.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package fifo_stream_pkg holds:
  - state enum {IDLE, RUN, DRAIN}, 2-bit encoding;
  - constant BUF_DEPTH=2.
- Sub-module fifo_stream_skid: the 2-entry registered buffer.
  - Inputs: wr (inflight), wdata, rd (handshake).
  - Outputs: occ, head data.
- Credit logic, counters and FSM stay in the top.

Test Plan:
- Reset during RUN with occ=2 → next cycle: m_valid=0, busy=0, fifo_rd_en=0; no done pulse.
- FIFO preloaded with 0x11..0x15, start len=5, m_ready=1 → rd_en for 5 consecutive cycles; beats 0x11..0x15 on consecutive cycles; m_last only on 0x15; done one cycle after the 0x15 handshake.
- len=0 start → done pulses next cycle; fifo_rd_en never asserts; busy stays 0.
- Backpressure: len=4, m_ready=0 for 10 cycles then 1 → exactly 2 pops issued while stalled; m_data holds the first word stable; all 4 delivered in order after release.
- Empty gaps: FIFO gets one word every 3 cycles, len=3 → rd_en only when fifo_empty=0; 3 beats, correct m_last, done once.
- start held high across completion, len=2 then len=1 → second burst begins only after returning to IDLE; start pulses while busy have no effect.
- With FIFO_STREAM_BEAT_CNT_EN: after the bursts above, beat_total equals the sum of delivered beats (e.g. 5+4+3=12).
